// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the RV32I memory-port controller: bus widths, stall
// bit positions and vectors, and FSM state encodings.
package mem_port_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int RegBus      = 32;

    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE  = '0;
    localparam logic [STALL_W-1:0] STALL_FETCH = STALL_W'((1 << STALL_PC) | (1 << STALL_IF));
    localparam logic [STALL_W-1:0] STALL_LOAD_USE =
        STALL_W'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
    localparam logic [STALL_W-1:0] STALL_LS =
        STALL_W'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID) | (1 << STALL_EX) | (1 << STALL_MEM));

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_LS_BUSY = 2'd2;

    // An outstanding load/store freezes everything up to MEM; a pending fetch
    // only holds pc/IF so ID receives a bubble.
    function automatic logic [STALL_W-1:0] stall_vec(input logic ls_out,
                                                     input logic id_stall,
                                                     input logic if_out);
        if (ls_out)
            return STALL_LS;
        else if (id_stall)
            return STALL_LOAD_USE;
        else if (if_out)
            return STALL_FETCH;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/mem_port_timeout.sv
// Bus-wait watchdog: down-counter loaded on grant, expires on its last busy cycle.
// Only instantiated when MEM_PORT_TIMEOUT_EN is defined.
module mem_port_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= CNT_LOAD;
        else if (run && (cnt != '0))
            cnt <= cnt - CNT_ONE;
    end

    // Terminal count of one marks the TIMEOUT_CYCLES-th busy cycle.
    assign expire = run && (cnt == CNT_ONE);

endmodule

// File: rtl/mem_port_ctrl.sv
// Unified-bus arbiter between IF and MEM with req/ack sequencing and stall merge.
// Optional bus-wait timeout is compiled in with MEM_PORT_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | bus free; grant LS first, else IF
// IF_BUSY    | fetch on the bus, waiting for bus_ack
// LS_BUSY    | load/store on the bus, waiting for bus_ack
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    output logic                   if_ack,
    output logic [RegBus-1:0]      if_rdata,
    input  logic                   ls_req,
    input  logic                   ls_we,
    input  logic [3:0]             ls_sel,
    input  logic [RegBus-1:0]      ls_addr,
    input  logic [RegBus-1:0]      ls_wdata,
    output logic                   ls_ack,
    output logic [RegBus-1:0]      ls_rdata,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [3:0]             bus_sel,
    output logic [RegBus-1:0]      bus_addr,
    output logic [RegBus-1:0]      bus_wdata,
    input  logic [RegBus-1:0]      bus_rdata,
    input  logic                   bus_ack,
    input  logic                   stallreq_id,
    input  logic                   br,
    output logic [STALL_W-1:0]     stall,
    output logic                   bus_err
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       kill;
    logic       busy;
    logic       grant_ls;
    logic       grant_if;
    logic       done;
    logic       expire;

    // A requester whose ack is pulsing this cycle is still holding req; it
    // must not be granted again.
    always_comb begin
        busy      = (state == ST_IF_BUSY) || (state == ST_LS_BUSY);
        grant_ls  = (state == ST_IDLE) && ls_req && !ls_ack;
        grant_if  = (state == ST_IDLE) && !grant_ls && if_req && !if_ack;
        done      = busy && (bus_ack || expire);
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_ls)
                    state_nxt = ST_LS_BUSY;
                else if (grant_if)
                    state_nxt = ST_IF_BUSY;
            end
            ST_IF_BUSY, ST_LS_BUSY: begin
                if (done)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus_req = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            kill      <= 1'b0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state  <= state_nxt;
            if_ack <= 1'b0;
            ls_ack <= 1'b0;

            if (grant_ls) begin
                bus_we    <= ls_we;
                bus_sel   <= ls_sel;
                bus_addr  <= ls_addr;
                bus_wdata <= ls_wdata;
            end else if (grant_if) begin
                bus_we    <= 1'b0;
                bus_sel   <= 4'b1111;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
            end

            if (done && (state == ST_LS_BUSY)) begin
                ls_ack   <= 1'b1;
                ls_rdata <= bus_ack ? bus_rdata : '0;
            end

            // A branch in the completion cycle also makes the fetch stale.
            if (done && (state == ST_IF_BUSY)) begin
                if_ack   <= !(kill || br);
                if_rdata <= bus_ack ? bus_rdata : '0;
                kill     <= 1'b0;
            end else if (br && ((state == ST_IF_BUSY) || grant_if)) begin
                kill <= 1'b1;
            end
        end
    end

    always_comb begin
        stall = STALL_NONE;
        if (rst_n)
            stall = stall_vec(ls_req && !ls_ack, stallreq_id, if_req && !if_ack);
    end

`ifdef MEM_PORT_TIMEOUT_EN
    mem_port_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (grant_ls || grant_if),
        .run    (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus_err <= 1'b0;
        else
            bus_err <= expire && !bus_ack;
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign bus_err        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: expected bus transactions and acks are
// queued by the stimulus and checked by an independent monitor.
module tb_mem_port_ctrl;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, stallreq_id, br, bus_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, bus_rdata;
    logic [3:0]  ls_sel;
    logic        if_ack, ls_ack, bus_req, bus_we, bus_err;
    logic [31:0] if_rdata, ls_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;

    int checks = 0;
    int errors = 0;
    int n_if_ack = 0;
    int wait_cfg = 0;
    bit slave_en = 1'b1;

    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem[logic [31:0]];

    mem_port_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_sel(ls_sel), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_id(stallreq_id), .br(br), .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Called at posedge+1; drops the request in the cycle after its ack.
    task automatic wait_ack(input bit is_ls, input int bound, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            seen = is_ls ? ls_ack : if_ack;
            n++;
        end
        chk(name, {71'd0, seen}, 72'd1);
        tick();
        if (is_ls) ls_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    // Bus slave: acks after wait_cfg wait cycles, stores on writes.
    initial begin
        int          wcnt = 0;
        logic [31:0] tmp;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
                wcnt    = 0;
            end else if (bus_req && slave_en) begin
                if (wcnt == wait_cfg) begin
                    tmp = mem.exists(bus_addr) ? mem[bus_addr] : 32'd0;
                    if (bus_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_sel[b]) tmp[8*b +: 8] = bus_wdata[8*b +: 8];
                        mem[bus_addr] = tmp;
                        bus_rdata     = 32'd0;
                    end else begin
                        bus_rdata = tmp;
                    end
                    bus_ack = 1'b1;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transaction or ack.
    initial begin
        logic bus_req_d = 1'b0;
        bus_t got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if_ack) begin
                    n_if_ack++;
                    if (if_q.size() == 0) chk("if_ack_unexpected", {71'd0, if_ack}, 72'd0);
                    else                  chk("if_rdata", {40'd0, if_rdata}, {40'd0, if_q.pop_front()});
                end
                if (ls_ack) begin
                    if (ls_q.size() == 0) chk("ls_ack_unexpected", {71'd0, ls_ack}, 72'd0);
                    else                  chk("ls_rdata", {40'd0, ls_rdata}, {40'd0, ls_q.pop_front()});
                end
                if (bus_req && !bus_req_d) begin
                    got = '{we: bus_we, sel: bus_sel, addr: bus_addr, wdata: bus_wdata};
                    if (bus_q.size() == 0) chk("bus_req_unexpected", {71'd0, bus_req}, 72'd0);
                    else                   chk("bus_txn", {3'd0, got}, {3'd0, bus_q.pop_front()});
                end
            end
            bus_req_d = bus_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        {if_req, ls_req, ls_we, stallreq_id, br} = '0;
        {if_addr, ls_addr, ls_wdata} = '0;
        ls_sel = '0;
        mem[32'h100] = 32'h00500093;
        mem[32'h104] = 32'h00A00113;
        mem[32'h200] = 32'h11111111;
        mem[32'h300] = 32'h22222222;

        at_neg();
        chk("rst_bus_req", {71'd0, bus_req}, 72'd0);
        chk("rst_acks",    {70'd0, if_ack, ls_ack}, 72'd0);
        chk("rst_stall",   {66'd0, stall}, 72'd0);
        chk("rst_bus_addr", {40'd0, bus_addr}, 72'd0);
        chk("rst_bus_err", {71'd0, bus_err}, 72'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 0-wait fetch
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h100;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0});
        if_q.push_back(32'h00500093);
        at_neg();
        chk("f0_stall_c0", {66'd0, stall}, {66'd0, 6'b000011});
        chk("f0_bus_req_c0", {71'd0, bus_req}, 72'd0);
        tick(); at_neg();
        chk("f0_bus_req_c1", {71'd0, bus_req}, 72'd1);
        chk("f0_stall_c1", {66'd0, stall}, {66'd0, 6'b000011});
        tick(); at_neg();
        chk("f0_if_ack_c2", {71'd0, if_ack}, 72'd1);
        chk("f0_stall_c2", {66'd0, stall}, 72'd0);
        tick();
        if_req = 1'b0;
        tick();

        // simultaneous IF + LS store: LS first
        wait_cfg = 1;
        if_req = 1'b1; if_addr = 32'h104;
        ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'hF; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF;
        bus_q.push_back('{we: 1'b1, sel: 4'hF, addr: 32'h2000, wdata: 32'hDEADBEEF});
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h104, wdata: 32'h0});
        ls_q.push_back(32'h0);
        if_q.push_back(32'h00A00113);
        at_neg();
        chk("sim_stall_c0", {66'd0, stall}, {66'd0, 6'b011111});
        tick(); at_neg();
        chk("sim_bus_we_c1", {71'd0, bus_we}, 72'd1);
        chk("sim_stall_c1", {66'd0, stall}, {66'd0, 6'b011111});
        tick(); at_neg();
        chk("sim_stall_c2", {66'd0, stall}, {66'd0, 6'b011111});
        tick(); at_neg();
        chk("sim_ls_ack_c3", {71'd0, ls_ack}, 72'd1);
        chk("sim_stall_c3", {66'd0, stall}, {66'd0, 6'b000011});
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        wait_ack(1'b0, 20, "sim_if_ack_timeout");

        // load back the stored word with partial byte enables
        ls_req = 1'b1; ls_sel = 4'b0011; ls_addr = 32'h2000; ls_wdata = 32'h0;
        bus_q.push_back('{we: 1'b0, sel: 4'b0011, addr: 32'h2000, wdata: 32'h0});
        ls_q.push_back(32'hDEADBEEF);
        wait_ack(1'b1, 20, "ld_ls_ack_timeout");

        // branch kills a 3-wait fetch, coinciding with a load-use stall
        wait_cfg = 3;
        n0 = n_if_ack;
        if_req = 1'b1; if_addr = 32'h200;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h200, wdata: 32'h0});
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h300, wdata: 32'h0});
        if_q.push_back(32'h22222222);
        at_neg();
        chk("kill_stall_c0", {66'd0, stall}, {66'd0, 6'b000011});
        tick(); tick();
        br = 1'b1; stallreq_id = 1'b1;
        at_neg();
        chk("kill_stall_br", {66'd0, stall}, {66'd0, 6'b000111});
        tick();
        br = 1'b0; stallreq_id = 1'b0; if_addr = 32'h300;
        tick(); tick(); at_neg();
        chk("kill_if_ack_c5", {71'd0, if_ack}, 72'd0);
        chk("kill_bus_idle_c5", {71'd0, bus_req}, 72'd0);
        tick(); at_neg();
        chk("kill_refetch_addr", {40'd0, bus_addr}, {40'd0, 32'h300});
        tick();
        wait_ack(1'b0, 20, "kill_refetch_timeout");
        chk("kill_if_ack_count", 72'(n_if_ack - n0), 72'd1);

        // load-use stall with idle bus, then LS raised
        wait_cfg = 0;
        stallreq_id = 1'b1;
        at_neg();
        chk("id_stall_idle", {66'd0, stall}, {66'd0, 6'b000111});
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_sel = 4'hF; ls_addr = 32'h104;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h104, wdata: 32'h0});
        ls_q.push_back(32'h00A00113);
        at_neg();
        chk("id_stall_ls", {66'd0, stall}, {66'd0, 6'b011111});
        tick();
        wait_ack(1'b1, 20, "id_ls_ack_timeout");
        stallreq_id = 1'b0;

        // reset in LS_BUSY
        wait_cfg = 5;
        ls_req = 1'b1; ls_addr = 32'h300;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h300, wdata: 32'h0});
        tick(); at_neg();
        chk("rstls_bus_req_busy", {71'd0, bus_req}, 72'd1);
        tick();
        rst_n = 1'b0;
        ls_req = 1'b0;
        #1;
        chk("rstls_bus_req", {71'd0, bus_req}, 72'd0);
        chk("rstls_outs", {2'd0, bus_we, bus_sel, bus_addr, if_ack, ls_ack, stall, bus_err},
            72'd0);
        chk("rstls_rdata", {8'd0, if_rdata, ls_rdata}, 72'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h100;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0});
        if_q.push_back(32'h00500093);
        at_neg();
        chk("rstls_new_stall", {66'd0, stall}, {66'd0, 6'b000011});
        tick();
        wait_ack(1'b0, 20, "rstls_if_ack_timeout");

`ifdef MEM_PORT_TIMEOUT_EN
        slave_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h400, wdata: 32'h0});
        if_q.push_back(32'h0);
        at_neg();
        for (int k = 1; k <= 4; k++) begin
            tick(); at_neg();
            chk("to_bus_req_hold", {71'd0, bus_req}, 72'd1);
            chk("to_bus_err_low", {71'd0, bus_err}, 72'd0);
        end
        tick(); at_neg();
        chk("to_bus_req_drop", {71'd0, bus_req}, 72'd0);
        chk("to_if_ack", {71'd0, if_ack}, 72'd1);
        chk("to_bus_err", {71'd0, bus_err}, 72'd1);
        tick();
        if_req = 1'b0;
        at_neg();
        chk("to_bus_err_pulse", {71'd0, bus_err}, 72'd0);
        slave_en = 1'b1;
        tick();
`endif

        tick(); tick();
        chk("if_q_drained",  72'(if_q.size()), 72'd0);
        chk("ls_q_drained",  72'(ls_q.size()), 72'd0);
        chk("bus_q_drained", 72'(bus_q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
